// File: rtl/memory_store_buffer_pkg.sv
// Shared types and configuration for the memory-stage store buffer.
package memory_store_buffer_pkg;

  localparam int unsigned store_buffer_depth      = 4;
  localparam int unsigned store_buffer_coalesce   = 0;
  localparam int unsigned store_buffer_addr_width = 32;
  localparam int unsigned data_width              = 32;
  localparam int unsigned be_width                = 4;
  // Entries hold a tag sized for the widest supported address; narrower addresses zero-extend.
  localparam int unsigned tag_width               = store_buffer_addr_width - 2;

  typedef struct packed {
    logic                  valid;
    logic [tag_width-1:0]  tag;
    logic [data_width-1:0] data;
    logic [be_width-1:0]   byte_en;
  } store_buffer_entry_t;

  // Overlay the enabled bytes of new_data onto old_data.
  function automatic logic [data_width-1:0] merge_bytes(input logic [data_width-1:0] old_data,
                                                        input logic [data_width-1:0] new_data,
                                                        input logic [be_width-1:0]   be);
    logic [data_width-1:0] merged;
    merged = old_data;
    for (int b = 0; b < int'(be_width); b++) begin
      if (be[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/memory_store_buffer_match.sv
// Youngest-first priority matcher of a load against buffered stores.
module memory_store_buffer_match
  import memory_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = store_buffer_depth
) (
  input  store_buffer_entry_t         entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]    head_idx,
  input  logic [tag_width-1:0]        load_tag,
  input  logic [be_width-1:0]         load_be,
  output logic                        hit,
  output logic                        conflict,
  output logic [$clog2(DEPTH)-1:0]    sel_idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]      idx;
  logic                  found;
  logic                  covered;
  logic [data_width-1:0] unused_data;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    idx         = '0;
    found       = 1'b0;
    sel_idx     = '0;
    unused_data = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx         = IDX_W'(head_idx + IDX_W'(k));
      unused_data = unused_data ^ entries[idx].data;
      if (entries[idx].valid && (entries[idx].tag == load_tag) &&
          ((entries[idx].byte_en & load_be) != '0)) begin
        found   = 1'b1;
        sel_idx = idx;
      end
    end
    covered  = ((entries[sel_idx].byte_en & load_be) == load_be);
    hit      = found && covered;
    conflict = found && !covered;
  end

endmodule

// File: rtl/memory_store_buffer.sv
// In-order store buffer with load forwarding and optional same-word coalescing.
module memory_store_buffer
  import memory_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = store_buffer_depth,
  parameter int unsigned ADDR_WIDTH = store_buffer_addr_width,
  parameter int unsigned COALESCE   = store_buffer_coalesce
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pushValid,
  output logic                         pushReady,
  input  logic [ADDR_WIDTH-1:0]        pushAddress,
  input  logic [31:0]                  pushData,
  input  logic [3:0]                   pushByteEnable,
  input  logic                         loadCheckValid,
  input  logic [ADDR_WIDTH-1:0]        loadAddress,
  input  logic [3:0]                   loadByteEnable,
  output logic                         forwardHit,
  output logic [31:0]                  forwardData,
  output logic                         loadConflict,
  input  logic                         drainAll,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         storeValid,
  output logic [ADDR_WIDTH-1:0]        storeAddress,
  output logic [31:0]                  storeData,
  output logic [3:0]                   storeByteEnable,
  input  logic                         storeComplete
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned TAG_W = ADDR_WIDTH - 2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_WIDTH > store_buffer_addr_width ||
      ADDR_WIDTH < 3) begin : g_bad_config
    $error("memory_store_buffer: unsupported DEPTH/ADDR_WIDTH");
  end

  store_buffer_entry_t entries [DEPTH];
  logic [PTR_W-1:0]     head_ptr, tail_ptr;
  logic [IDX_W-1:0]     head_idx, tail_idx, last_idx, sel_idx;
  logic [tag_width-1:0] push_tag, load_tag;
  logic                 full, is_empty, coalesce_ok;
  logic                 push_new, push_merge, pop;
  logic                 match_hit, match_conflict;
  logic                 unused_low;

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];
  assign last_idx = tail_idx - IDX_W'(1);
  assign push_tag = tag_width'(pushAddress[ADDR_WIDTH-1:2]);
  assign load_tag = tag_width'(loadAddress[ADDR_WIDTH-1:2]);
  assign unused_low = ^{pushAddress[1:0], loadAddress[1:0]};

  // Wrap bit separates full from empty when the index bits agree.
  assign is_empty = (head_ptr == tail_ptr);
  assign full     = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);

  // Merge only into a tail that is not also the head currently offered to memory.
  assign coalesce_ok = (COALESCE != 0) && !is_empty && entries[last_idx].valid &&
                       (entries[last_idx].tag == push_tag) && (last_idx != head_idx);

  assign pushReady  = !full || coalesce_ok;
  assign push_merge = pushValid && coalesce_ok;
  assign push_new   = pushValid && !coalesce_ok && !full;
  assign pop        = storeValid && storeComplete;

  // Entry array and pointer updates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) entries[i] <= '0;
    end else begin
      if (pop) begin
        entries[head_idx].valid <= 1'b0;
        head_ptr                <= head_ptr + PTR_W'(1);
      end
      if (push_new) begin
        entries[tail_idx] <= '{valid: 1'b1, tag: push_tag, data: pushData,
                               byte_en: pushByteEnable};
        tail_ptr          <= tail_ptr + PTR_W'(1);
      end
      if (push_merge) begin
        entries[last_idx].data    <= merge_bytes(entries[last_idx].data, pushData, pushByteEnable);
        entries[last_idx].byte_en <= entries[last_idx].byte_en | pushByteEnable;
      end
    end
  end

  assign empty           = is_empty;
  assign occupancy       = OCC_W'(tail_ptr - head_ptr);
  assign storeValid      = !is_empty;
  assign storeAddress    = {entries[head_idx].tag[TAG_W-1:0], 2'b00};
  assign storeData       = entries[head_idx].data;
  assign storeByteEnable = entries[head_idx].byte_en;

  memory_store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .entries  (entries),
    .head_idx (head_idx),
    .load_tag (load_tag),
    .load_be  (loadByteEnable),
    .hit      (match_hit),
    .conflict (match_conflict),
    .sel_idx  (sel_idx)
  );

  assign forwardHit   = loadCheckValid && match_hit;
  assign loadConflict = loadCheckValid && match_conflict;
  assign forwardData  = entries[sel_idx].data;

  a_push_be_nonzero: assert property (@(posedge clock) disable iff (!reset)
    pushValid |-> pushByteEnable != 4'b0000);
  a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset)
    push_new |-> !full);
  a_occupancy_bound: assert property (@(posedge clock) disable iff (!reset)
    occupancy <= OCC_W'(DEPTH));
  a_fence_progress: assert property (@(posedge clock) disable iff (!reset)
    (drainAll && !is_empty) |-> storeValid);

endmodule
